// File: rtl/ym_bus_master.sv
// Bus-cycle initiator for a pair of YM2149 PSGs: queues CPU register requests
// and turns each one into BDIR/BC/DA/A8 strobe sequences, returning read data.
module ym_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 1,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 1,
    parameter bit ADDR_CACHE = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic       req_chip,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DA,
    output logic [1:0] A8,
    input  logic [7:0] DO0,
    input  logic [7:0] DO1
);
    // state  | meaning
    // IDLE   | waiting for a queued request; pops and latches it
    // A_SET  | address on DA, BC=1, BDIR low (setup)
    // A_STB  | address strobe, BDIR high
    // A_HLD  | address hold, BDIR low; updates the per-chip address cache
    // D_SET  | write data on DA, BC=0, BDIR low (setup)
    // D_STB  | write strobe, BDIR high
    // D_HLD  | write hold, BDIR low
    // R_WAIT | read mode (BC=1, BDIR=0); samples DO on the last cycle
    // R_DONE | read release, rsp_valid on the first cycle

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(T_SETUP + T_PULSE + T_HOLD + 1);

    localparam logic [CW-1:0] L_SET = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_PUL = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] L_HLD = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_RW  = CW'(T_SETUP + T_PULSE - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SET, S_A_STB, S_A_HLD,
        S_D_SET, S_D_STB, S_D_HLD, S_R_WAIT, S_R_DONE
    } state_t;

    typedef struct packed {
        logic       rd;
        logic       chip;
        logic [3:0] addr;
        logic [7:0] data;
    } req_t;

    req_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    req_t          head;
    req_t          cur;
    logic          push;
    logic          pop;
    logic          hit;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last;

    logic [1:0]    cache_v;
    logic [3:0]    cache_a [2];

    assign req_ready = (count != FULL_CNT);
    assign head      = mem[rd_ptr];
    assign pop       = (state == S_IDLE) && (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push      = req_valid && (req_ready || pop);
    assign hit       = ADDR_CACHE && cache_v[head.chip] && (cache_a[head.chip] == head.addr);
    assign last      = (cnt == '0);
    assign busy      = (count != '0) || (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: req_rd, chip: req_chip, addr: req_addr, data: req_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur      <= '0;
            cache_v  <= 2'b00;
            cache_a  <= '{default: 4'h0};
            rsp_data <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop) cur <= head;
            if (state == S_A_HLD && last) begin
                cache_v[cur.chip] <= 1'b1;
                cache_a[cur.chip] <= cur.addr;
            end
            if (state == S_R_WAIT && last) begin
                rsp_data <= cur.chip ? DO1 : DO0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pop) begin
                    if (!hit) begin
                        state_nxt = S_A_SET;
                        cnt_nxt   = L_SET;
                    end else if (head.rd) begin
                        state_nxt = S_R_WAIT;
                        cnt_nxt   = L_RW;
                    end else begin
                        state_nxt = S_D_SET;
                        cnt_nxt   = L_SET;
                    end
                end
            end
            S_A_SET: if (last) begin state_nxt = S_A_STB; cnt_nxt = L_PUL; end
            S_A_STB: if (last) begin state_nxt = S_A_HLD; cnt_nxt = L_HLD; end
            S_A_HLD: begin
                if (last) begin
                    state_nxt = cur.rd ? S_R_WAIT : S_D_SET;
                    cnt_nxt   = cur.rd ? L_RW : L_SET;
                end
            end
            S_D_SET:  if (last) begin state_nxt = S_D_STB;  cnt_nxt = L_PUL; end
            S_D_STB:  if (last) begin state_nxt = S_D_HLD;  cnt_nxt = L_HLD; end
            S_D_HLD:  if (last) begin state_nxt = S_IDLE;   cnt_nxt = '0;    end
            S_R_WAIT: if (last) begin state_nxt = S_R_DONE; cnt_nxt = L_HLD; end
            S_R_DONE: if (last) begin state_nxt = S_IDLE;   cnt_nxt = '0;    end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        BDIR      = 1'b0;
        BC        = 1'b0;
        DA        = 8'h00;
        A8        = 2'b00;
        rsp_valid = 1'b0;
        if (state != S_IDLE) begin
            A8 = cur.chip ? 2'b10 : 2'b01;
        end
        unique case (state)
            S_A_SET, S_A_HLD: begin
                BC = 1'b1;
                DA = {4'h0, cur.addr};
            end
            S_A_STB: begin
                BDIR = 1'b1;
                BC   = 1'b1;
                DA   = {4'h0, cur.addr};
            end
            S_D_SET, S_D_HLD: DA = cur.data;
            S_D_STB: begin
                BDIR = 1'b1;
                DA   = cur.data;
            end
            S_R_WAIT: BC = 1'b1;
            S_R_DONE: rsp_valid = (cnt == L_HLD);
            default: ;
        endcase
    end
endmodule
